// File: rtl/writeback.sv
// writeback: final pipeline stage retiring register writes, stores (req/ack) and traps.
// Defining WRITEBACK_INSTRET_EN adds the 64-bit instret retired-instruction counter port.
module writeback #(
   parameter int STORE_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ex_stall,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_rd_val,
   input  logic [31:0] ex_inst_pc,
   input  logic        ex_jump,
   input  logic [31:0] ex_jump_pc,
   input  logic        ex_exception_valid,
   input  logic [5:0]  ex_exception_num,
   input  logic [31:0] ex_exception_val,
   input  logic        ex_store_valid,
   input  logic [1:0]  ex_store_size,
   input  logic [31:0] ex_store_addr,
   input  logic [31:0] ex_store_val,
   output logic        mem_wr_req,
   output logic [31:0] mem_wr_addr,
   output logic [31:0] mem_wr_data,
   output logic [3:0]  mem_wr_strb,
   input  logic        mem_wr_ack,
   output logic        rf_wr_en,
   output logic [4:0]  rf_wr_rd,
   output logic [31:0] rf_wr_val,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_out,
`ifdef WRITEBACK_INSTRET_EN
   output logic [63:0] instret,
`endif
   output logic        trap_valid,
   output logic [5:0]  trap_num,
   output logic [31:0] trap_val,
   output logic [31:0] trap_pc
);
   localparam int CW = $clog2(STORE_TIMEOUT);
   typedef enum logic {IDLE, STORE} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rf_en_q, rf_en_d, redir_q, redir_d, flush_q, flush_d, trap_q, trap_d;
   logic [4:0]    rf_rd_q, rf_rd_d;
   logic [31:0]   rf_val_q, rf_val_d, redir_pc_q, redir_pc_d;
   logic [5:0]    trap_num_q, trap_num_d;
   logic [31:0]   trap_val_q, trap_val_d, trap_pc_q, trap_pc_d;
   logic [31:0]   addr_q, addr_d, data_q, data_d, st_addr_q, st_addr_d, st_pc_q, st_pc_d;
   logic [3:0]    strb_q, strb_d;
   logic          accept, misaligned, bad_store, timeout;
   assign ex_stall   = (state_q == STORE) | flush_q;
   assign accept     = ex_valid & ~ex_stall;
   assign misaligned = (ex_store_size == 2'd1 & ex_store_addr[0]) | (ex_store_size == 2'd2 & |ex_store_addr[1:0]);
   assign bad_store  = ex_store_valid & (ex_store_size == 2'd3 | misaligned);
   assign timeout    = cnt_q == CW'(STORE_TIMEOUT - 1);
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rf_en_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_val_d   = rf_val_q;
      redir_d    = 1'b0;
      redir_pc_d = redir_pc_q;
      flush_d    = 1'b0;
      trap_d     = 1'b0;
      trap_num_d = trap_num_q;
      trap_val_d = trap_val_q;
      trap_pc_d  = trap_pc_q;
      addr_d     = addr_q;
      data_d     = data_q;
      strb_d     = strb_q;
      st_addr_d  = st_addr_q;
      st_pc_d    = st_pc_q;
      if (state_q == STORE) begin
         cnt_d = cnt_q + 1'b1;
         if (mem_wr_ack) begin
            state_d = IDLE;
         end else if (timeout) begin
            state_d    = IDLE;
            trap_d     = 1'b1;
            flush_d    = 1'b1;
            trap_num_d = 6'd7;
            trap_val_d = st_addr_q;
            trap_pc_d  = st_pc_q;
         end
      end else if (accept) begin
         if (ex_exception_valid | bad_store) begin
            trap_d     = 1'b1;
            flush_d    = 1'b1;
            trap_pc_d  = ex_inst_pc;
            trap_num_d = ex_exception_valid ? ex_exception_num : ex_store_size == 2'd3 ? 6'd2 : 6'd6;
            trap_val_d = ex_exception_valid ? ex_exception_val : ex_store_addr;
         end else if (ex_store_valid) begin
            state_d   = STORE;
            cnt_d     = '0;
            st_addr_d = ex_store_addr;
            st_pc_d   = ex_inst_pc;
            addr_d    = {ex_store_addr[31:2], 2'b00};
            // byte and halfword data is replicated across lanes; the strobe picks the live lanes
            strb_d    = ex_store_size == 2'd0 ? 4'b0001 << ex_store_addr[1:0] :
                        ex_store_size == 2'd1 ? 4'b0011 << {ex_store_addr[1], 1'b0} : 4'hF;
            data_d    = ex_store_size == 2'd0 ? {4{ex_store_val[7:0]}} :
                        ex_store_size == 2'd1 ? {2{ex_store_val[15:0]}} : ex_store_val;
         end else begin
            rf_en_d  = |ex_rd;
            rf_rd_d  = ex_rd;
            rf_val_d = ex_rd_val;
            redir_d  = ex_jump;
            flush_d  = ex_jump;
            if (ex_jump) redir_pc_d = ex_jump_pc;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rf_en_q    <= 1'b0;
         rf_rd_q    <= '0;
         rf_val_q   <= '0;
         redir_q    <= 1'b0;
         redir_pc_q <= '0;
         flush_q    <= 1'b0;
         trap_q     <= 1'b0;
         trap_num_q <= '0;
         trap_val_q <= '0;
         trap_pc_q  <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         strb_q     <= '0;
         st_addr_q  <= '0;
         st_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rf_en_q    <= rf_en_d;
         rf_rd_q    <= rf_rd_d;
         rf_val_q   <= rf_val_d;
         redir_q    <= redir_d;
         redir_pc_q <= redir_pc_d;
         flush_q    <= flush_d;
         trap_q     <= trap_d;
         trap_num_q <= trap_num_d;
         trap_val_q <= trap_val_d;
         trap_pc_q  <= trap_pc_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         strb_q     <= strb_d;
         st_addr_q  <= st_addr_d;
         st_pc_q    <= st_pc_d;
      end
   end
   assign mem_wr_req     = state_q == STORE;
   assign mem_wr_addr    = addr_q;
   assign mem_wr_data    = data_q;
   assign mem_wr_strb    = strb_q;
   assign rf_wr_en       = rf_en_q;
   assign rf_wr_rd       = rf_rd_q;
   assign rf_wr_val      = rf_val_q;
   assign redirect_valid = redir_q;
   assign redirect_pc    = redir_pc_q;
   assign flush_out      = flush_q;
   assign trap_valid     = trap_q;
   assign trap_num       = trap_num_q;
   assign trap_val       = trap_val_q;
   assign trap_pc        = trap_pc_q;
`ifdef WRITEBACK_INSTRET_EN
   logic [63:0] instret_q, instret_d;
   logic        retire;
   assign retire    = (state_q == STORE & mem_wr_ack) | (accept & ~ex_exception_valid & ~ex_store_valid);
   assign instret_d = retire ? instret_q + 64'd1 : instret_q;
   always_ff @(posedge clk) begin
      if (reset) instret_q <= '0;
      else instret_q <= instret_d;
   end
   assign instret = instret_q;
`endif
endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed stimulus with a queue scoreboard; a negedge monitor checks every
// retire/trap/redirect pulse and every store request cycle against the queued expectations.
module tb_writeback;
   localparam int TO = 64;
   logic        clk = 1'b0, reset;
   logic        ex_valid, ex_stall, ex_jump, ex_exception_valid, ex_store_valid;
   logic [4:0]  ex_rd;
   logic [31:0] ex_rd_val, ex_inst_pc, ex_jump_pc, ex_exception_val, ex_store_addr, ex_store_val;
   logic [5:0]  ex_exception_num;
   logic [1:0]  ex_store_size;
   logic        mem_wr_req, mem_wr_ack, rf_wr_en, redirect_valid, flush_out, trap_valid;
   logic [31:0] mem_wr_addr, mem_wr_data, rf_wr_val, redirect_pc, trap_val, trap_pc;
   logic [3:0]  mem_wr_strb;
   logic [4:0]  rf_wr_rd;
   logic [5:0]  trap_num;
`ifdef WRITEBACK_INSTRET_EN
   logic [63:0] instret;
`endif
   int n_vec = 0, n_err = 0;

   typedef struct packed {
      logic rf; logic [4:0] rd; logic [31:0] val;
      logic rv; logic [31:0] rpc;
      logic tv; logic [5:0] tn; logic [31:0] tval; logic [31:0] tpc;
      logic fl;
   } ev_t;
   typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} st_t;
   ev_t exp_q[$];
   st_t st_q[$];

   writeback #(.STORE_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
      .ex_rd(ex_rd), .ex_rd_val(ex_rd_val), .ex_inst_pc(ex_inst_pc),
      .ex_jump(ex_jump), .ex_jump_pc(ex_jump_pc),
      .ex_exception_valid(ex_exception_valid), .ex_exception_num(ex_exception_num),
      .ex_exception_val(ex_exception_val), .ex_store_valid(ex_store_valid),
      .ex_store_size(ex_store_size), .ex_store_addr(ex_store_addr), .ex_store_val(ex_store_val),
      .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_wr_strb(mem_wr_strb), .mem_wr_ack(mem_wr_ack),
      .rf_wr_en(rf_wr_en), .rf_wr_rd(rf_wr_rd), .rf_wr_val(rf_wr_val),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_out(flush_out),
`ifdef WRITEBACK_INSTRET_EN
      .instret(instret),
`endif
      .trap_valid(trap_valid), .trap_num(trap_num), .trap_val(trap_val), .trap_pc(trap_pc)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout act=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic ev_t mk(input logic rf, input logic [4:0] rd, input logic [31:0] val,
                              input logic rv, input logic [31:0] rpc, input logic tv,
                              input logic [5:0] tn, input logic [31:0] tval, input logic [31:0] tpc);
      ev_t e;
      e.rf = rf;   e.rd = rf ? rd : 5'd0;  e.val = rf ? val : 32'd0;
      e.rv = rv;   e.rpc = rv ? rpc : 32'd0;
      e.tv = tv;   e.tn = tv ? tn : 6'd0;  e.tval = tv ? tval : 32'd0; e.tpc = tv ? tpc : 32'd0;
      e.fl = rv | tv;
      return e;
   endfunction

   // monitor: pops one expectation per output pulse cycle, one store expectation per request
   ev_t obs;
   st_t so, cur = '0;
   logic req_prev = 1'b0;
   always @(negedge clk) begin
      if (!reset) begin
         if (rf_wr_en | redirect_valid | trap_valid | flush_out) begin
            obs = mk(rf_wr_en, rf_wr_rd, rf_wr_val, redirect_valid, redirect_pc,
                     trap_valid, trap_num, trap_val, trap_pc);
            obs.fl = flush_out;
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_retire act=%0h exp=none", obs);
            end else chk("retire", obs, exp_q.pop_front());
         end
         if (mem_wr_req) begin
            if (!req_prev) begin
               if (st_q.size() == 0) begin
                  n_vec++; n_err++;
                  $display("FAIL unexpected_store act=%0h exp=none", mem_wr_addr);
                  cur = '0;
               end else cur = st_q.pop_front();
            end
            so.a = mem_wr_addr; so.d = mem_wr_data; so.s = mem_wr_strb;
            chk("store_req", so, cur);
         end
      end
      req_prev = mem_wr_req;
   end

   task automatic clr();
      ex_valid = 0; ex_rd = 0; ex_rd_val = 0; ex_inst_pc = 0; ex_jump = 0; ex_jump_pc = 0;
      ex_exception_valid = 0; ex_exception_num = 0; ex_exception_val = 0;
      ex_store_valid = 0; ex_store_size = 0; ex_store_addr = 0; ex_store_val = 0;
   endtask

   task automatic issue();
      bit acc = 0;
      int b = 0;
      ex_valid = 1;
      do begin
         @(negedge clk);
         acc = !ex_stall;
         @(posedge clk); #1;
         b++;
      end while (!acc && b < 200);
      clr();
      if (!acc) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout act=stalled exp=accepted");
      end
   endtask

   task automatic alu(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc, input logic exp_en);
      clr(); ex_rd = rd; ex_rd_val = val; ex_inst_pc = pc;
      if (exp_en) exp_q.push_back(mk(1, rd, val, 0, 0, 0, 0, 0, 0));
      issue();
   endtask

   task automatic jmp(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc, input logic [31:0] jpc);
      clr(); ex_rd = rd; ex_rd_val = val; ex_inst_pc = pc; ex_jump = 1; ex_jump_pc = jpc;
      exp_q.push_back(mk(1, rd, val, 1, jpc, 0, 0, 0, 0));
      issue();
   endtask

   task automatic tr(input logic exv, input logic [5:0] en, input logic [31:0] ev, input logic stv,
                     input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] pc,
                     input logic [5:0] exp_num, input logic [31:0] exp_val);
      clr(); ex_exception_valid = exv; ex_exception_num = en; ex_exception_val = ev;
      ex_store_valid = stv; ex_store_size = sz; ex_store_addr = addr; ex_inst_pc = pc;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, exp_num, exp_val, pc));
      issue();
   endtask

   task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] val, input logic [31:0] pc,
                     input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] es);
      st_t s;
      clr(); ex_store_valid = 1; ex_store_size = sz; ex_store_addr = addr; ex_store_val = val; ex_inst_pc = pc;
      s.a = ea; s.d = ed; s.s = es;
      st_q.push_back(s);
      issue();
   endtask

   task automatic ack_after(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("store_busy", {mem_wr_req, ex_stall}, 2'b11);
         if (i == n - 1) mem_wr_ack = 1;
         @(posedge clk); #1;
      end
      mem_wr_ack = 0;
      @(negedge clk);
      chk("store_done", {mem_wr_req, ex_stall}, 2'b00);
      @(posedge clk); #1;
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {ex_stall, mem_wr_req, mem_wr_addr, mem_wr_data, mem_wr_strb, rf_wr_en, rf_wr_rd,
               rf_wr_val, redirect_valid, redirect_pc, flush_out, trap_valid, trap_num, trap_val, trap_pc}, '0);
`ifdef WRITEBACK_INSTRET_EN
      chk({nm, "_instret"}, instret, '0);
`endif
   endtask

   initial begin
      int n;
      clr(); mem_wr_ack = 0; reset = 1;
      repeat (2) @(posedge clk); #1;
      @(negedge clk);
      chk_zero("reset_outputs");
      @(posedge clk); #1;
      reset = 0;
      @(posedge clk); #1;
      // register retires, back to back, including rd=0
      alu(5'd5, 32'h1234, 32'h100, 1);
      alu(5'd0, 32'h55, 32'h104, 0);
      alu(5'd7, 32'hFFFF_FFFF, 32'h108, 1);
      // jump; a bundle shown only during the flush cycle must vanish
      jmp(5'd1, 32'h110, 32'h10C, 32'h80);
      clr(); ex_valid = 1; ex_rd = 5'd9; ex_rd_val = 32'hDEAD;
      @(negedge clk);
      chk("flush_stall", {flush_out, ex_stall}, 2'b11);
      @(posedge clk); #1;
      clr();
      alu(5'd2, 32'h22, 32'h80, 1);
      // stores
      st(2'd0, 32'h1003, 32'hAB, 32'h200, 32'h1000, 32'hABABABAB, 4'h8);
      ack_after(3);
      st(2'd1, 32'h2002, 32'h1234_5678, 32'h204, 32'h2000, 32'h5678_5678, 4'hC);
      ack_after(1);
      st(2'd0, 32'h1001, 32'h1CD, 32'h208, 32'h1000, 32'hCDCDCDCD, 4'h2);
      ack_after(2);
      st(2'd2, 32'h3000, 32'hCAFE_BABE, 32'h20C, 32'h3000, 32'hCAFE_BABE, 4'hF);
      ack_after(1);
      st(2'd1, 32'h2000, 32'hBEEF, 32'h210, 32'h2000, 32'hBEEF_BEEF, 4'h3);
      ack_after(2);
      mem_wr_ack = 1;
      @(posedge clk); #1;
      mem_wr_ack = 0;
      @(negedge clk);
      chk("ack_idle_ignored", {mem_wr_req, ex_stall}, 2'b00);
      @(posedge clk); #1;
      // traps and their priority
      tr(0, 0, 0, 1, 2'd2, 32'h1002, 32'h300, 6'd6, 32'h1002);
      tr(0, 0, 0, 1, 2'd3, 32'h1003, 32'h304, 6'd2, 32'h1003);
      tr(0, 0, 0, 1, 2'd1, 32'h1001, 32'h308, 6'd6, 32'h1001);
      tr(1, 6'd5, 32'h55, 1, 2'd2, 32'h1002, 32'h30C, 6'd5, 32'h55);
      tr(1, 6'd13, 32'hBAD, 0, 2'd0, 32'h0, 32'h310, 6'd13, 32'hBAD);
      alu(5'd3, 32'h33, 32'h314, 1);
      // store timeout
      exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 6'd7, 32'h2002, 32'h400));
      st(2'd1, 32'h2002, 32'hA5A5, 32'h400, 32'h2000, 32'hA5A5_A5A5, 4'hC);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!mem_wr_req) break;
         n++;
      end
      chk("timeout_req_cycles", n, TO);
      chk("timeout_flush_stall", ex_stall, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("timeout_idle", {mem_wr_req, ex_stall}, 2'b00);
      @(posedge clk); #1;
      // reset in the middle of a store
      st(2'd2, 32'h4000, 32'h1122_3344, 32'h500, 32'h4000, 32'h1122_3344, 4'hF);
      @(negedge clk);
      chk("req_before_reset", mem_wr_req, 1'b1);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk_zero("reset_mid_store");
      @(posedge clk); #1;
      reset = 0;
      @(posedge clk); #1;
      // retire mix after reset
      alu(5'd4, 32'h44, 32'h600, 1);
      alu(5'd0, 32'h0, 32'h604, 0);
      st(2'd0, 32'h5002, 32'h77, 32'h608, 32'h5000, 32'h7777_7777, 4'h4);
      ack_after(1);
      tr(0, 0, 0, 1, 2'd2, 32'h5001, 32'h60C, 6'd6, 32'h5001);
      repeat (3) @(posedge clk);
      #1;
`ifdef WRITEBACK_INSTRET_EN
      chk("instret_count", instret, 64'd3);
`endif
      chk("exp_q_drained", exp_q.size(), 0);
      chk("st_q_drained", st_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
